// File: rtl/pipelined_addsub.sv
// Valid/ready pipelined adder/subtractor: the carry chain is cut into num_regs
// equal chunks, one chunk added per stage, with a sideband tag carried alongside.
module pipelined_addsub #(
  parameter int inp_data_width = 8,
  parameter int num_regs       = 4,
  parameter int tag_width      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [inp_data_width-1:0] in_a,
  input  logic [inp_data_width-1:0] in_b,
  input  logic                      in_sub,
  input  logic [tag_width-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [inp_data_width:0]   outp,
  output logic [tag_width-1:0]      out_tag
);
  localparam int W = inp_data_width;
  localparam int N = num_regs;
  localparam int C = W / N;

  logic         stall;
  logic [W-1:0] b_eff;

  // Subtraction is A + ~B + 1; the +1 enters as the carry-in of chunk 0.
  assign b_eff = in_sub ? ~in_b : in_b;

  for (genvar k = 1; k <= N; k++) begin : stg
    logic                   ld;
    logic                   src_sub;
    logic                   cin;
    logic [tag_width-1:0]   src_tag;
    logic [W-(k-1)*C-1:0]   src_a;
    logic [W-(k-1)*C-1:0]   src_b;
    logic [k*C-1:0]         nxt_sum;
    logic [C:0]             csum;

    logic                   vld_p;
    logic                   sub_p;
    logic                   cy_p;
    logic [tag_width-1:0]   tag_p;
    logic [k*C-1:0]         sum_p;

    assign csum = {1'b0, src_a[C-1:0]} + {1'b0, src_b[C-1:0]} + {{C{1'b0}}, cin};

    // Stage boundary: stage 1 takes operands from the ports, later stages
    // consume the lowest still-pending chunk held by the stage before.
    if (k == 1) begin : src
      assign ld      = in_valid;
      assign src_sub = in_sub;
      assign src_tag = in_tag;
      assign src_a   = in_a;
      assign src_b   = b_eff;
      assign cin     = in_sub;
      assign nxt_sum = csum[C-1:0];
    end else begin : src
      assign ld      = stg[k-1].vld_p;
      assign src_sub = stg[k-1].sub_p;
      assign src_tag = stg[k-1].tag_p;
      assign src_a   = stg[k-1].rem.a_p;
      assign src_b   = stg[k-1].rem.b_p;
      assign cin     = stg[k-1].cy_p;
      assign nxt_sum = {csum[C-1:0], stg[k-1].sum_p};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (!stall) begin
        vld_p <= ld;
      end
    end

    // Data only loads behind a valid transaction, so bubbles leave the
    // output word untouched and it reads zero until the first result.
    always_ff @(posedge clk) begin
      if (rst) begin
        sub_p <= 1'b0;
        cy_p  <= 1'b0;
        tag_p <= '0;
        sum_p <= '0;
      end else if (!stall && ld) begin
        sub_p <= src_sub;
        cy_p  <= csum[C];
        tag_p <= src_tag;
        sum_p <= nxt_sum;
      end
    end

    if (k < N) begin : rem
      logic [W-k*C-1:0] a_p;
      logic [W-k*C-1:0] b_p;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_p <= '0;
          b_p <= '0;
        end else if (!stall && ld) begin
          a_p <= src_a[W-(k-1)*C-1:C];
          b_p <= src_b[W-(k-1)*C-1:C];
        end
      end
    end
  end

  // Output stage: the final carry is inverted for subtract so the top bit
  // reads as the borrow, giving a W+1-bit two's complement difference.
  assign out_valid = stg[N].vld_p;
  assign outp      = {stg[N].cy_p ^ stg[N].sub_p, stg[N].sum_p};
  assign out_tag   = stg[N].tag_p;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !rst;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: vector table, backpressure, mid-stream
// reset and a depth sweep with num_regs = 1 and 8 instances.
module tb_pipelined_addsub;
  localparam int W  = 8;
  localparam int TW = 4;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W:0]    exp;
  } vec_t;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sub;
  logic          out_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;

  logic          in_ready,  out_valid;
  logic [W:0]    outp;
  logic [TW-1:0] out_tag;
  logic          in_ready1, out_valid1;
  logic [W:0]    outp1;
  logic [TW-1:0] out_tag1;
  logic          in_ready8, out_valid8;
  logic [W:0]    outp8;
  logic [TW-1:0] out_tag8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 tb_clk = ~tb_clk;

  pipelined_addsub #(.inp_data_width(W), .num_regs(4), .tag_width(TW)) dut (
    .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .outp(outp), .out_tag(out_tag)
  );

  pipelined_addsub #(.inp_data_width(W), .num_regs(1), .tag_width(TW)) dut1 (
    .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(1'b1), .outp(outp1), .out_tag(out_tag1)
  );

  pipelined_addsub #(.inp_data_width(W), .num_regs(8), .tag_width(TW)) dut8 (
    .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid8), .out_ready(1'b1), .outp(outp8), .out_tag(out_tag8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub, input logic [TW-1:0] tag,
                              input logic [W:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.tag = tag; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_tag = v.tag;
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // One transaction into all three depths; checks result and measured latency.
  task automatic sweep(input vec_t v);
    int lat1, lat8;
    lat1 = 0;
    lat8 = 0;
    in_valid = 1'b1;
    drive(v);
    for (int t = 1; t <= 20; t++) begin
      step();
      in_valid = 1'b0;
      if (out_valid1 && lat1 == 0) begin
        lat1 = t;
        check("sweep_n1_outp", 32'(outp1), 32'(v.exp));
        check("sweep_n1_tag", 32'(out_tag1), 32'(v.tag));
      end
      if (out_valid8 && lat8 == 0) begin
        lat8 = t;
        check("sweep_n8_outp", 32'(outp8), 32'(v.exp));
        check("sweep_n8_tag", 32'(out_tag8), 32'(v.tag));
      end
    end
    check("sweep_n1_latency", 32'(lat1), 1);
    check("sweep_n8_latency", 32'(lat8), 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    vec_t bq[$];
    vec_t sb[$];
    int   sent, got, stalls;
    logic [W:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;

    // Reset state
    step(); step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_outp", 32'(outp), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_outp_n8", 32'(outp8), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Table: single add, subtracts, 16 carry-crossing adds, extremes
    vt.push_back(mk(8'd200, 8'd100, 1'b0, 4'd5, 9'h12C));
    vt.push_back(mk(8'd5,   8'd10,  1'b1, 4'd1, 9'h1FB));
    vt.push_back(mk(8'd10,  8'd5,   1'b1, 4'd2, 9'h005));
    vt.push_back(mk(8'd77,  8'd77,  1'b1, 4'd3, 9'h000));
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(8'(i), 8'd255, 1'b0, 4'(i), 9'(255 + i)));
    vt.push_back(mk(8'd255, 8'd255, 1'b0, 4'd9, 9'h1FE));
    vt.push_back(mk(8'd0,   8'd1,   1'b1, 4'd6, 9'h1FF));

    for (int cyc = 0; cyc < vt.size() + 4; cyc++) begin
      if (cyc >= 4) begin
        check("tbl_valid", 32'(out_valid), 1);
        check("tbl_outp", 32'(outp), 32'(vt[cyc-4].exp));
        check("tbl_tag", 32'(out_tag), 32'(vt[cyc-4].tag));
      end else begin
        check("tbl_early_valid", 32'(out_valid), 0);
      end
      if (cyc < vt.size()) begin
        in_valid = 1'b1;
        drive(vt[cyc]);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    check("tbl_drained_valid", 32'(out_valid), 0);

    // Backpressure: 4 in flight, out_ready low for 3 cycles
    for (int i = 0; i < 8; i++) begin
      e = i[0] ? 9'({1'b0, 8'(17*i+3)} - {1'b0, 8'(200-9*i)})
               : 9'({1'b0, 8'(17*i+3)} + {1'b0, 8'(200-9*i)});
      bq.push_back(mk(8'(17*i+3), 8'(200-9*i), i[0], 4'(i+8), e));
    end
    sent = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 8);
      if (sent < 8) drive(bq[sent]);
      #1;
      if (out_valid && sb.size() == 0) check("bp_spurious_valid", 32'(out_valid), 0);
      if (out_valid && !out_ready && sb.size() != 0) begin
        stalls++;
        check("bp_stall_in_ready", 32'(in_ready), 0);
        check("bp_stall_outp_held", 32'(outp), 32'(sb[0].exp));
        check("bp_stall_tag_held", 32'(out_tag), 32'(sb[0].tag));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        check("bp_outp", 32'(outp), 32'(sb[0].exp));
        check("bp_tag", 32'(out_tag), 32'(sb[0].tag));
        void'(sb.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(bq[sent]);
        sent++;
      end
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_results_received", 32'(got), 8);
    check("bp_stall_cycles", 32'(stalls), 3);
    check("bp_scoreboard_empty", 32'(sb.size()), 0);
    #1;
    check("bp_drained_valid", 32'(out_valid), 0);

    // Reset with 3 transactions in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive(mk(8'(i+1), 8'(i+2), 1'b0, 4'(i+1), 9'h0));
      step();
    end
    in_valid = 1'b1;
    drive(mk(8'hAA, 8'h11, 1'b0, 4'hF, 9'h0));
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    drive(mk(8'd40, 8'd2, 1'b0, 4'hC, 9'h0));
    #1;
    check("midrst_flushed_valid", 32'(out_valid), 0);
    check("midrst_in_ready_after", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      if (t == 4) begin
        check("midrst_new_valid", 32'(out_valid), 1);
        check("midrst_new_outp", 32'(outp), 42);
        check("midrst_new_tag", 32'(out_tag), 32'hC);
      end else begin
        check("midrst_no_ghost_valid", 32'(out_valid), 0);
      end
      step();
    end

    // Depth sweep
    repeat (10) step();
    sweep(mk(8'd255, 8'd255, 1'b0, 4'd3, 9'h1FE));
    sweep(mk(8'd0,   8'd1,   1'b1, 4'd7, 9'h1FF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
